// File: rtl/serial_rx6.sv
// 8N1 UART receiver that assembles six consecutive bytes (byte 0 first, LSB first)
// into one 48-bit word, with stop-bit framing and inter-byte gap checking.
module serial_rx6 #(
  parameter int CLK_PER_BIT = 50,
  parameter int GAP_BITS    = 4,
  parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [47:0] data,
  output logic        new_data,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam int GAP_LIMIT = GAP_BITS * CLK_PER_BIT;
  localparam int GAP_SIZE  = $clog2(GAP_LIMIT + 1);
  localparam logic [CTR_SIZE-1:0] CTR_HALF = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
  localparam logic [CTR_SIZE-1:0] CTR_FULL = CTR_SIZE'(CLK_PER_BIT - 1);
  localparam logic [GAP_SIZE-1:0] GAP_LAST = GAP_SIZE'(GAP_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4,
    FLUSH = 3'd5
  } state_t;

  state_t              state;
  logic                rx_m;
  logic                rx_s;
  logic [CTR_SIZE-1:0] ctr;
  logic [GAP_SIZE-1:0] gap_ctr;
  logic [2:0]          bit_cnt;
  logic [2:0]          byte_cnt;
  logic [7:0]          shift;
  logic [39:0]         asm_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      ctr         <= '0;
      gap_ctr     <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      shift       <= '0;
      asm_reg     <= '0;
      data        <= '0;
      new_data    <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_m        <= rx;
      rx_s        <= rx_m;
      new_data    <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= (state != IDLE);

      case (state)
        IDLE: begin
          byte_cnt <= '0;
          if (!rx_s) begin
            ctr   <= '0;
            state <= START;
          end
        end

        START: begin
          if (ctr == CTR_HALF) begin
            ctr <= '0;
            if (rx_s) begin
              // Glitch: mid-frame, resume the gap with whatever budget is left.
              state <= (byte_cnt == 3'd0) ? IDLE : GAP;
            end else begin
              bit_cnt <= '0;
              state   <= DATA;
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end

        DATA: begin
          if (ctr == CTR_FULL) begin
            ctr   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_cnt == 3'd7) state <= STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end

        STOP: begin
          if (ctr == CTR_FULL) begin
            ctr <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
              byte_cnt  <= '0;
              state     <= FLUSH;
            end else if (byte_cnt != 3'd5) begin
              asm_reg[{byte_cnt, 3'b000} +: 8] <= shift;
              byte_cnt <= byte_cnt + 1'b1;
              gap_ctr  <= '0;
              state    <= GAP;
            end else begin
              data     <= {shift, asm_reg};
              new_data <= 1'b1;
              byte_cnt <= '0;
              state    <= IDLE;
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end

        GAP: begin
          if (!rx_s) begin
            ctr   <= '0;
            state <= START;
          end else if (gap_ctr == GAP_LAST) begin
            timeout_err <= 1'b1;
            byte_cnt    <= '0;
            ctr         <= '0;
            state       <= IDLE;
          end else begin
            gap_ctr <= gap_ctr + 1'b1;
          end
        end

        FLUSH: begin
          // Need one full bit-time of continuous idle before hunting for a start.
          if (!rx_s) begin
            ctr <= '0;
          end else if (ctr == CTR_FULL) begin
            ctr   <= '0;
            state <= IDLE;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end

        default: begin
          ctr   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx6.sv
// Directed bench for serial_rx6: one instance at 50 clk/bit, one at 4 clk/bit.
module tb_serial_rx6;

  logic        clk;
  logic        rst;
  logic        rx_a;
  logic        rx_b;
  logic [47:0] data_a, data_b;
  logic        new_data_a, new_data_b;
  logic        frame_err_a, frame_err_b;
  logic        timeout_err_a, timeout_err_b;
  logic        busy_a, busy_b;

  int checks;
  int errors;
  int cyc;
  int nd_a, fe_a, to_a, overlap_a, fe_cyc_a;
  int nd_b, fe_b, to_b, overlap_b;

  serial_rx6 #(.CLK_PER_BIT(50), .GAP_BITS(4)) dut (
    .clk(clk), .rst(rst), .rx(rx_a), .data(data_a), .new_data(new_data_a),
    .frame_err(frame_err_a), .timeout_err(timeout_err_a), .busy(busy_a)
  );

  serial_rx6 #(.CLK_PER_BIT(4), .GAP_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .rx(rx_b), .data(data_b), .new_data(new_data_b),
    .frame_err(frame_err_b), .timeout_err(timeout_err_b), .busy(busy_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (new_data_a) nd_a <= nd_a + 1;
    if (frame_err_a) begin
      fe_a     <= fe_a + 1;
      fe_cyc_a <= cyc;
    end
    if (timeout_err_a) to_a <= to_a + 1;
    if (32'(new_data_a) + 32'(frame_err_a) + 32'(timeout_err_a) > 1) overlap_a <= overlap_a + 1;
    if (new_data_b) nd_b <= nd_b + 1;
    if (frame_err_b) fe_b <= fe_b + 1;
    if (timeout_err_b) to_b <= to_b + 1;
    if (32'(new_data_b) + 32'(frame_err_b) + 32'(timeout_err_b) > 1) overlap_b <= overlap_b + 1;
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks: all line changes happen on the falling edge
  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_b = v;
    else rx_a = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input bit sel, input int cpb, input logic [7:0] b, input logic stop_bit);
    set_line(sel, 1'b0);
    idle(cpb);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, b[i]);
      idle(cpb);
    end
    set_line(sel, stop_bit);
    idle(cpb);
    set_line(sel, 1'b1);
  endtask

  task automatic send_frame(input bit sel, input int cpb, input logic [47:0] f);
    for (int k = 0; k < 6; k++) send_byte(sel, cpb, f[8*k +: 8], 1'b1);
  endtask

  int nd0, fe0, to0, t_start;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    nd_a = 0; fe_a = 0; to_a = 0; overlap_a = 0; fe_cyc_a = 0;
    nd_b = 0; fe_b = 0; to_b = 0; overlap_b = 0;
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    idle(3);
    check("reset_data", data_a, 48'h0);
    check("reset_new_data", {47'h0, new_data_a}, 48'h0);
    check("reset_frame_err", {47'h0, frame_err_a}, 48'h0);
    check("reset_timeout_err", {47'h0, timeout_err_a}, 48'h0);
    check("reset_busy", {47'h0, busy_a}, 48'h0);
    check("reset_data_cpb4", data_b, 48'h0);
    rst = 1'b0;
    idle(10);

    // Back-to-back frame
    nd0 = nd_a; fe0 = fe_a; to0 = to_a;
    send_frame(1'b0, 50, 48'h665544332211);
    idle(100);
    check("b2b_new_data_count", 48'(nd_a - nd0), 48'd1);
    check("b2b_data", data_a, 48'h665544332211);
    check("b2b_frame_err_count", 48'(fe_a - fe0), 48'd0);
    check("b2b_timeout_count", 48'(to_a - to0), 48'd0);
    check("b2b_busy_idle", {47'h0, busy_a}, 48'h0);

    // 3 idle bit-times between bytes 2 and 3 stays inside the gap budget
    nd0 = nd_a; to0 = to_a;
    send_byte(1'b0, 50, 8'h11, 1'b1);
    send_byte(1'b0, 50, 8'h22, 1'b1);
    send_byte(1'b0, 50, 8'h33, 1'b1);
    idle(150);
    send_byte(1'b0, 50, 8'h44, 1'b1);
    send_byte(1'b0, 50, 8'h55, 1'b1);
    send_byte(1'b0, 50, 8'h66, 1'b1);
    idle(100);
    check("gap150_new_data_count", 48'(nd_a - nd0), 48'd1);
    check("gap150_data", data_a, 48'h665544332211);
    check("gap150_timeout_count", 48'(to_a - to0), 48'd0);

    // 5 idle bit-times drops the partial frame
    nd0 = nd_a; to0 = to_a;
    send_byte(1'b0, 50, 8'h11, 1'b1);
    send_byte(1'b0, 50, 8'h22, 1'b1);
    send_byte(1'b0, 50, 8'h33, 1'b1);
    idle(250);
    idle(100);
    check("gap250_timeout_count", 48'(to_a - to0), 48'd1);
    check("gap250_new_data_count", 48'(nd_a - nd0), 48'd0);
    check("gap250_busy_idle", {47'h0, busy_a}, 48'h0);
    nd0 = nd_a; to0 = to_a;
    send_frame(1'b0, 50, 48'hA5A4A3A2A1A0);
    idle(100);
    check("after_timeout_new_data_count", 48'(nd_a - nd0), 48'd1);
    check("after_timeout_data", data_a, 48'hA5A4A3A2A1A0);
    check("after_timeout_timeout_count", 48'(to_a - to0), 48'd0);

    // Stop bit of byte 4 sampled low
    nd0 = nd_a; fe0 = fe_a;
    for (int k = 0; k < 4; k++) send_byte(1'b0, 50, 8'(8'h11 * (k + 1)), 1'b1);
    t_start = cyc;
    send_byte(1'b0, 50, 8'h55, 1'b0);
    idle(150);
    check("ferr_count", 48'(fe_a - fe0), 48'd1);
    check("ferr_new_data_count", 48'(nd_a - nd0), 48'd0);
    check("ferr_data_held", data_a, 48'hA5A4A3A2A1A0);
    checks++;
    assert ((fe_cyc_a - t_start) >= 476 && (fe_cyc_a - t_start) <= 480) else begin
      errors++;
      $error("FAIL ferr_latency observed %0d expected 476..480", fe_cyc_a - t_start);
    end
    nd0 = nd_a; fe0 = fe_a;
    send_frame(1'b0, 50, 48'h665544332211);
    idle(100);
    check("after_ferr_new_data_count", 48'(nd_a - nd0), 48'd1);
    check("after_ferr_data", data_a, 48'h665544332211);
    check("after_ferr_frame_err_count", 48'(fe_a - fe0), 48'd0);

    // 10-cycle low glitch while idle
    nd0 = nd_a; fe0 = fe_a; to0 = to_a;
    rx_a = 1'b0;
    idle(5);
    check("glitch_busy_high", {47'h0, busy_a}, 48'h1);
    idle(5);
    rx_a = 1'b1;
    idle(60);
    check("glitch_busy_low", {47'h0, busy_a}, 48'h0);
    check("glitch_pulses", 48'((nd_a - nd0) + (fe_a - fe0) + (to_a - to0)), 48'd0);

    // Reset in the middle of byte 2
    nd0 = nd_a;
    send_byte(1'b0, 50, 8'h11, 1'b1);
    send_byte(1'b0, 50, 8'h22, 1'b1);
    rx_a = 1'b0;
    idle(50);
    for (int i = 0; i < 4; i++) begin
      rx_a = 1'(i & 1);
      idle(50);
    end
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_data", data_a, 48'h0);
    check("async_rst_busy", {47'h0, busy_a}, 48'h0);
    check("async_rst_pulses", {45'h0, new_data_a, frame_err_a, timeout_err_a}, 48'h0);
    rx_a = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(100);
    check("rst_no_new_data", 48'(nd_a - nd0), 48'd0);
    check("rst_data_stays_zero", data_a, 48'h0);
    nd0 = nd_a;
    send_frame(1'b0, 50, 48'h060504030201);
    idle(100);
    check("after_rst_new_data_count", 48'(nd_a - nd0), 48'd1);
    check("after_rst_data", data_a, 48'h060504030201);

    // Minimum bit time
    send_frame(1'b1, 4, 48'hAA55018000FF);
    idle(40);
    check("cpb4_new_data_count", 48'(nd_b), 48'd1);
    check("cpb4_data", data_b, 48'hAA55018000FF);
    check("cpb4_errors", 48'(fe_b + to_b), 48'd0);

    check("pulse_overlap_a", 48'(overlap_a), 48'd0);
    check("pulse_overlap_b", 48'(overlap_b), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
